// File: rtl/calc_ctrl.sv
// Keypad calculator sequencer: debounced key capture, two signed decimal
// operands, add/subtract with chaining, and a signed-magnitude display value.
module calc_ctrl #(
  parameter int MAX_DIGITS = 4,
  parameter int W          = 14,
  parameter int SETTLE     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_pressed,
  input  logic         is_num,
  input  logic         is_op,
  input  logic [1:0]   which_op,
  input  logic [3:0]   which_num,
  output logic [W-1:0] mag,
  output logic         neg,
  output logic         overflow,
  output logic [2:0]   state,
  output logic         key_evt
);

  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [W+1:0] LIM = (W+2)'(10**MAX_DIGITS - 1);

  typedef enum logic [2:0] {
    ENTA = 3'd0,
    OPW  = 3'd1,
    ENTB = 3'd2,
    RES  = 3'd3,
    ERR  = 3'd4
  } st_t;

  st_t st;
  assign state = st;

  // key capture state
  logic          kp_q;
  logic [SW-1:0] scnt;
  logic          k_num, k_op;
  logic [1:0]    k_wop;
  logic [3:0]    k_nval;
  logic          kp_rise;
  assign kp_rise = key_pressed & ~kp_q;

  // operands
  logic signed [W:0] A, B;
  logic [1:0]        op;
  logic [DW-1:0]     dcnt;

  // Settle counter: start on a rising edge when idle, sample the key code on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      kp_q    <= 1'b0;
      scnt    <= '0;
      key_evt <= 1'b0;
      k_num   <= 1'b0;
      k_op    <= 1'b0;
      k_wop   <= '0;
      k_nval  <= '0;
    end else begin
      kp_q    <= key_pressed;
      key_evt <= 1'b0;
      if (scnt != '0) begin
        scnt <= scnt - 1'b1;
        if (scnt == SW'(1)) begin
          k_num   <= is_num;
          k_op    <= is_op;
          k_wop   <= which_op;
          k_nval  <= which_num;
          key_evt <= 1'b1;
        end
      end else if (kp_rise) begin
        scnt <= SW'(SETTLE);
      end
    end
  end

  // event decode; a digit wins if the reader flags both, op code 0 is a null key
  logic ev_num, ev_pm, ev_eq;
  assign ev_num = key_evt & k_num;
  assign ev_pm  = key_evt & ~k_num & k_op & (k_wop == 2'd1 || k_wop == 2'd2);
  assign ev_eq  = key_evt & ~k_num & k_op & (k_wop == 2'd3);

  logic signed [W:0] dval;
  assign dval = $signed((W+1)'(k_nval));

  // Digit accumulate for whichever operand is being entered (B only in ENTB).
  logic signed [W:0] acc_src, acc_val;
  logic [DW-1:0]     acc_dcnt;
  logic              acc_hold;
  always_comb begin
    acc_src  = (st == ENTB) ? B : A;
    acc_hold = (acc_src == '0 && k_nval == 4'd0) || (dcnt == DW'(MAX_DIGITS));
    acc_val  = acc_src;
    acc_dcnt = dcnt;
    if (!acc_hold) begin
      acc_val  = (acc_src <<< 3) + (acc_src <<< 1) + dval;
      acc_dcnt = dcnt + 1'b1;
    end
  end

  // Result in one extra bit so the sum of two in-range operands never wraps.
  logic signed [W+1:0] r;
  logic [W+1:0]        r_abs;
  logic                r_ovf;
  assign r     = (op == 2'd2) ? ({A[W], A} - {B[W], B}) : ({A[W], A} + {B[W], B});
  assign r_abs = r[W+1] ? -r : r;
  assign r_ovf = r_abs > LIM;

  function automatic logic signed [W+1:0] sx(input logic signed [W:0] x);
    return {x[W], x};
  endfunction

  function automatic logic [W-1:0] f_mag(input logic signed [W+1:0] x);
    return W'(x[W+1] ? -x : x);
  endfunction

  // Sequencing FSM with registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ENTA;
      A        <= '0;
      B        <= '0;
      op       <= '0;
      dcnt     <= '0;
      mag      <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (st)
        ENTA: begin
          if (ev_num) begin
            A    <= acc_val;
            dcnt <= acc_dcnt;
            mag  <= f_mag(sx(acc_val));
            neg  <= acc_val[W];
          end else if (ev_pm) begin
            op <= k_wop;
            st <= OPW;
          end
        end
        OPW: begin
          if (ev_num) begin
            B    <= dval;
            dcnt <= DW'(k_nval != 4'd0);
            mag  <= W'(k_nval);
            neg  <= 1'b0;
            st   <= ENTB;
          end else if (ev_pm) begin
            op <= k_wop;
          end
        end
        ENTB: begin
          if (ev_num) begin
            B    <= acc_val;
            dcnt <= acc_dcnt;
            mag  <= f_mag(sx(acc_val));
            neg  <= acc_val[W];
          end else if (ev_pm || ev_eq) begin
            if (r_ovf) begin
              overflow <= 1'b1;
              mag      <= '0;
              neg      <= 1'b0;
              st       <= ERR;
            end else begin
              A   <= r[W:0];
              mag <= f_mag(r);
              neg <= r[W+1];
              if (ev_pm) begin
                op <= k_wop;
                st <= OPW;
              end else begin
                st <= RES;
              end
            end
          end
        end
        RES: begin
          if (ev_num) begin
            A    <= dval;
            dcnt <= DW'(k_nval != 4'd0);
            mag  <= W'(k_nval);
            neg  <= 1'b0;
            st   <= ENTA;
          end else if (ev_pm) begin
            op <= k_wop;
            st <= OPW;
          end
        end
        ERR: begin
          if (ev_num) begin
            overflow <= 1'b0;
            A        <= dval;
            dcnt     <= DW'(k_nval != 4'd0);
            mag      <= W'(k_nval);
            neg      <= 1'b0;
            st       <= ENTA;
          end
        end
        default: st <= ENTA;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: table of key presses with expected display
// state, plus hand-written reset-mid-settle and edge-at-expiry sequences.
module tb_calc_ctrl;
  localparam int SETTLE = 4;
  localparam int W      = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_pressed;
  logic         is_num;
  logic         is_op;
  logic [1:0]   which_op;
  logic [3:0]   which_num;
  logic [W-1:0] mag;
  logic         neg;
  logic         overflow;
  logic [2:0]   state;
  logic         key_evt;

  calc_ctrl #(.MAX_DIGITS(4), .W(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .key_pressed(key_pressed), .is_num(is_num),
    .is_op(is_op), .which_op(which_op), .which_num(which_num),
    .mag(mag), .neg(neg), .overflow(overflow), .state(state), .key_evt(key_evt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // kind: 0 digit, 1 operator (val = which_op), 2 reset
  typedef struct {
    int kind;
    int val;
    int emag;
    int eneg;
    int eovf;
    int est;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int k, input int v, input int m, input int n, input int o, input int s);
    vec_t e;
    e.kind = k; e.val = v; e.emag = m; e.eneg = n; e.eovf = o; e.est = s;
    tbl.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_pressed = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full press: samples key_evt around the expected latch edge, the
  // display just before and just after the expected update edge.
  task automatic press(input int kind, input int val,
                       output int ev_early, output int ev_at, output int ev_after,
                       output int pre_mag, output int pre_st,
                       output int p_mag, output int p_neg, output int p_ovf, output int p_st);
    @(negedge clk);
    is_num    = (kind == 0);
    is_op     = (kind == 1);
    which_num = (kind == 0) ? 4'(val) : 4'd0;
    which_op  = (kind == 1) ? 2'(val) : 2'd0;
    key_pressed = 1'b1;
    @(posedge clk);                       // edge seen here (t)
    for (int k = 1; k < SETTLE; k++) @(posedge clk);
    #1 ev_early = int'(key_evt);          // t+SETTLE-1
    @(posedge clk);
    #1 ev_at = int'(key_evt);             // t+SETTLE
    pre_mag = int'(mag);
    pre_st  = int'(state);
    @(posedge clk);
    #1 ev_after = int'(key_evt);          // t+SETTLE+1
    p_mag = int'(mag);
    p_neg = int'(neg);
    p_ovf = int'(overflow);
    p_st  = int'(state);
    repeat (2) @(posedge clk);
    @(negedge clk);
    key_pressed = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int e0, e1, e2, pm, ps, m, n, o, s;
    int prev_mag, prev_st, cnt;

    rst = 1'b0; key_pressed = 1'b0; is_num = 1'b0; is_op = 1'b0;
    which_op = 2'd0; which_num = 4'd0;

    // basic add, null key, ignored '=', RES handling
    add(2, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0);
    add(0, 2, 12, 0, 0, 0);
    add(1, 0, 12, 0, 0, 0);
    add(1, 3, 12, 0, 0, 0);
    add(1, 1, 12, 0, 0, 1);
    add(0, 3, 3, 0, 0, 2);
    add(1, 3, 15, 0, 0, 3);
    add(1, 3, 15, 0, 0, 3);
    add(1, 1, 15, 0, 0, 1);
    add(0, 5, 5, 0, 0, 2);
    add(1, 3, 20, 0, 0, 3);
    add(0, 8, 8, 0, 0, 0);
    // negative result
    add(2, 0, 0, 0, 0, 0);
    add(0, 5, 5, 0, 0, 0);
    add(1, 2, 5, 0, 0, 1);
    add(0, 9, 9, 0, 0, 2);
    add(1, 3, 4, 1, 0, 3);
    // leading zeros, digit limit, then overflow and recovery
    add(2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 9, 9, 0, 0, 0);
    add(0, 9, 99, 0, 0, 0);
    add(0, 9, 999, 0, 0, 0);
    add(0, 9, 9999, 0, 0, 0);
    add(0, 7, 9999, 0, 0, 0);
    add(1, 1, 9999, 0, 0, 1);
    add(0, 1, 1, 0, 0, 2);
    add(1, 3, 0, 0, 1, 4);
    add(1, 1, 0, 0, 1, 4);
    add(0, 3, 3, 0, 0, 0);
    // chaining and operator replace
    add(2, 0, 0, 0, 0, 0);
    add(0, 2, 2, 0, 0, 0);
    add(1, 1, 2, 0, 0, 1);
    add(1, 2, 2, 0, 0, 1);
    add(0, 3, 3, 0, 0, 2);
    add(1, 1, 1, 1, 0, 1);
    add(0, 4, 4, 0, 0, 2);
    add(1, 3, 3, 0, 0, 3);

    prev_mag = 0;
    prev_st  = 0;
    foreach (tbl[i]) begin
      if (tbl[i].kind == 2) begin
        do_reset();
        chk($sformatf("row%0d rst mag", i), int'(mag), 0);
        chk($sformatf("row%0d rst neg", i), int'(neg), 0);
        chk($sformatf("row%0d rst ovf", i), int'(overflow), 0);
        chk($sformatf("row%0d rst state", i), int'(state), 0);
        chk($sformatf("row%0d rst evt", i), int'(key_evt), 0);
      end else begin
        press(tbl[i].kind, tbl[i].val, e0, e1, e2, pm, ps, m, n, o, s);
        chk($sformatf("row%0d evt early", i), e0, 0);
        chk($sformatf("row%0d evt latch", i), e1, 1);
        chk($sformatf("row%0d evt after", i), e2, 0);
        chk($sformatf("row%0d pre mag", i), pm, prev_mag);
        chk($sformatf("row%0d pre state", i), ps, prev_st);
        chk($sformatf("row%0d mag", i), m, tbl[i].emag);
        chk($sformatf("row%0d neg", i), n, tbl[i].eneg);
        chk($sformatf("row%0d ovf", i), o, tbl[i].eovf);
        chk($sformatf("row%0d state", i), s, tbl[i].est);
      end
      prev_mag = tbl[i].emag;
      prev_st  = tbl[i].est;
    end

    // reset asserted mid-settle: outputs clear and the pending key is dropped
    @(negedge clk);
    is_num = 1'b1; is_op = 1'b0; which_num = 4'd6; which_op = 2'd0;
    key_pressed = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    key_pressed = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst mag", int'(mag), 0);
    chk("midrst neg", int'(neg), 0);
    chk("midrst ovf", int'(overflow), 0);
    chk("midrst state", int'(state), 0);
    cnt = 0;
    repeat (2 * SETTLE) begin
      @(negedge clk);
      cnt += int'(key_evt);
    end
    chk("midrst no evt", cnt, 0);
    chk("midrst mag after", int'(mag), 0);

    // a second rising edge on the expiry cycle is ignored
    @(negedge clk);
    is_num = 1'b1; is_op = 1'b0; which_num = 4'd1; which_op = 2'd0;
    key_pressed = 1'b1;
    @(posedge clk);                       // t
    repeat (SETTLE - 2) @(posedge clk);   // t+SETTLE-2
    @(negedge clk);
    key_pressed = 1'b0;                   // low across t+SETTLE-1
    @(negedge clk);
    key_pressed = 1'b1;                   // rises into t+SETTLE
    cnt = 0;
    repeat (3 * SETTLE) begin
      @(negedge clk);
      cnt += int'(key_evt);
    end
    key_pressed = 1'b0;
    repeat (2) @(negedge clk);
    chk("expiry edge evt count", cnt, 1);
    chk("expiry edge mag", int'(mag), 1);
    press(0, 2, e0, e1, e2, pm, ps, m, n, o, s);
    chk("after expiry evt", e1, 1);
    chk("after expiry mag", m, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the keypad calculator. Consumes decoded key events from the keyboard reader (`key_pressed`, `is_num`, `is_op`, `which_op`, `which_num`), all in the `clk` domain. It builds two signed decimal operands, applies add or subtract on `=` or on a chained operator, and drives a signed-magnitude value plus status to the display path.

## Interface
- `MAX_DIGITS`, default 4: maximum decimal digits per entered operand.
- `W`, default 14: magnitude width. The constraint 10^MAX_DIGITS-1 < 2^W is mandatory.
- `SETTLE`, default 4: cycles from the `key_pressed` rising edge to sampling of the key code. This covers the reader's sync pipeline. Must be ≥1.
- `clk`, in, 1: system clock (hf domain).
- `rst`, in, 1: reset. Synchronous, active-high.
- `key_pressed`, in, 1: level from the keyboard reader. High while a press is held.
- `is_num`, in, 1: current key is a digit.
- `is_op`, in, 1: current key is an operator.
- `which_op`, in, 2: operator code. 1 = add, 2 = subtract, 3 = equals, 0 = none.
- `which_num`, in, 4: digit value 0–9.
- `mag`, out, W: displayed magnitude.
- `neg`, out, 1: displayed value is negative.
- `overflow`, out, 1: error flag. Sticky until a digit key or `rst`.
- `state`, out, 3: current FSM state encoding, for debug and display blanking.
- `key_evt`, out, 1: one-cycle strobe when a key is accepted.

## Operation
**Key capture**
- `kp_q` registers `key_pressed`. A rising edge is `key_pressed & ~kp_q`.
- On an edge with no settle in progress, load the settle counter with SETTLE. Edges that arrive while a settle is running are ignored.
- When the counter expires, latch `is_num`, `is_op`, `which_op` and `which_num`, and pulse `key_evt` for one cycle.
- `is_op` with `which_op`=0 is a null key. It raises `key_evt` but the FSM ignores it.

**Registers**
- `A` and `B`: signed operands, W+1 bits.
- `op`: 2 bits.
- `dcnt`: digit counter.
- Accumulate rule: `X <= X*10 + d`, computed as `(X<<3)+(X<<1)+d`.
- Leading zero: when X=0 and d=0, X is unchanged and `dcnt` is unchanged.
- When `dcnt`=MAX_DIGITS, further digits are ignored.
- Compute: `R = A+B` (op=1) or `A-B` (op=2), in W+2-bit signed arithmetic. If |R| > 10^MAX_DIGITS-1, go to ERR.

**States** (encodings 0–4)
- ENTA (0), the reset state.
  - Digit: accumulate into A.
  - +/−: store `op`, go to OPW.
  - `=`: ignored.
  - Display shows A.
- OPW (1).
  - Digit: B=d, `dcnt`=(d≠0), go to ENTB. Display shows B.
  - +/−: replace `op`.
  - `=`: ignored.
- ENTB (2).
  - Digit: accumulate into B. Display shows B.
  - +/−: compute, A=R, `op`=new operator, go to OPW. Display shows R (chaining).
  - `=`: compute, A=R, go to RES. Display shows R.
- RES (3).
  - Digit: A=d, `dcnt`=(d≠0), go to ENTA.
  - +/−: `op`=key, go to OPW, with A retaining R.
  - `=`: ignored.
- ERR (4).
  - On entry: `overflow`=1, `mag`=0, `neg`=0.
  - Digit: clear `overflow`, A=d, go to ENTA.
  - Operators: ignored.

**Display rule:** `mag`=|X| and `neg`=(X<0) for the displayed register. A displayed zero always has `neg`=0.

## Timing
**Reset values** (`rst` sampled high at a posedge):
- `mag`=0, `neg`=0, `overflow`=0, `state`=ENTA, `key_evt`=0.
- A, B, `op`, `dcnt` and the settle counter all 0.
- `kp_q` = 0.
- `rst` aborts any settle in progress; no `key_evt` follows.

**Key path**
- Edge seen at posedge t: the key code is latched at posedge t+SETTLE, and `key_evt` is high for the cycle after that edge.
- The FSM transitions and `mag`/`neg`/`overflow` update at posedge t+SETTLE+1. Total latency is SETTLE+1 edges.

**Rates and simultaneous events**
- At most one event is accepted per press. The minimum spacing between accepted events is SETTLE+1 cycles.
- A new rising edge on the same cycle the counter expires is ignored.

**Arithmetic limits**
- Operands satisfy |A|, |B| ≤ 10^MAX_DIGITS-1. The compute path never wraps.

## Test plan
- **Reset:** assert `rst` mid-settle. Required: all outputs at reset values, `state`=0, and no `key_evt` for 2×SETTLE cycles after release.
- **Basic add:** press 1,2,+,3,=. Required: `mag` shows 12, then 3, then 15 with `neg`=0 and `state`=RES. Each update lands exactly SETTLE+1 cycles after its press edge.
- **Negative result:** press 5,−,9,=. Required: `mag`=4, `neg`=1.
- **Digit limit and leading zeros:** press 0,0,9,9,9,9,7. Required: `mag`=9999, with the 7 ignored.
- **Overflow:** press 9999,+,1,=. Required: `overflow`=1, `mag`=0, `state`=ERR. Then press + (still ERR), then 3. Required: `overflow`=0, `mag`=3, `state`=ENTA.
- **Chaining and operator replace:** press 2,+,−,3,+,4,=. Required: display shows 2, then 3, then −1 at the second + (`mag`=1, `neg`=1), then 4, and the final result is `mag`=3, `neg`=0.
